// File: rtl/irrig_pkg.sv
// -----------------------------------------------------------------------------
// irrig_pkg
// Shared definitions for the irrigation mode controller:
//   - state_t      : controller states (IDLE, FILL, DRIP, SPRAY, CLEAN, FAULT)
//   - MODE_*       : 2-bit phase codes driven on {ff2,ff1} to the phase timer
//   - VLV_*        : bit positions inside the valve vector
//   - outs_t       : bundle of all registered controller outputs
//   - helper functions that decode a state into its mode code, valve vector
//     and "is an active phase" flag
// -----------------------------------------------------------------------------
package irrig_pkg;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FILL  = 3'd1,
      S_DRIP  = 3'd2,
      S_SPRAY = 3'd3,
      S_CLEAN = 3'd4,
      S_FAULT = 3'd5
   } state_t;

   // Phase codes seen by the downstream timer on {ff2,ff1}.
   localparam logic [1:0] MODE_FILL  = 2'b00;
   localparam logic [1:0] MODE_DRIP  = 2'b01;
   localparam logic [1:0] MODE_SPRAY = 2'b10;
   localparam logic [1:0] MODE_CLEAN = 2'b11;

   // Valve vector layout.
   localparam int VLV_IN    = 0;
   localparam int VLV_DRIP  = 1;
   localparam int VLV_SPRAY = 2;
   localparam int VLV_DRAIN = 3;
   localparam int VLV_N     = 4;

   typedef struct packed {
      logic [1:0]       mode;
      logic             mode_load;
      logic             active;
      logic [VLV_N-1:0] valves;
      logic             fault;
   } outs_t;

   // IDLE and FAULT share the FILL code; `active` tells them apart.
   function automatic logic [1:0] mode_of(state_t s);
      logic [1:0] m;
      m = MODE_FILL;
      case (s)
         S_DRIP:  m = MODE_DRIP;
         S_SPRAY: m = MODE_SPRAY;
         S_CLEAN: m = MODE_CLEAN;
         default: m = MODE_FILL;
      endcase
      return m;
   endfunction

   function automatic logic is_phase(state_t s);
      return (s == S_FILL) || (s == S_DRIP) || (s == S_SPRAY) || (s == S_CLEAN);
   endfunction

   // One-hot (or all-zero) valve vector: at most one valve ever opens.
   function automatic logic [VLV_N-1:0] valves_of(state_t s);
      logic [VLV_N-1:0] v;
      v = '0;
      case (s)
         S_FILL:  v[VLV_IN]    = 1'b1;
         S_DRIP:  v[VLV_DRIP]  = 1'b1;
         S_SPRAY: v[VLV_SPRAY] = 1'b1;
         S_CLEAN: v[VLV_DRAIN] = 1'b1;
         default: v = '0;
      endcase
      return v;
   endfunction

endpackage

// File: rtl/irrigacao_fsm_watchdog.sv
// -----------------------------------------------------------------------------
// fill_watchdog
// Counts clock cycles spent filling the tank and flags the last allowed cycle.
// Ports:
//   clk    : system clock, rising edge
//   rst_n  : synchronous reset, active-low
//   clr    : synchronous clear (wins over en)
//   en     : count enable, one increment per clk
//   tc     : terminal count, 1 while the count equals FILL_TIMEOUT-1
// The controller forces FAULT (which clears the count) when tc is reached, so
// the counter never needs to go past FILL_TIMEOUT and cannot wrap.
// -----------------------------------------------------------------------------
module fill_watchdog #(
   parameter int FILL_TIMEOUT = 1000,
   parameter int CNT_W        = 10
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic tc
);

   localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(FILL_TIMEOUT - 1);

   logic [CNT_W-1:0] cnt;

   // NOTE: reset is synchronous (only seen at the clock edge), and sequential
   // state uses non-blocking assignments so every flop updates from the
   // values that existed before the edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign tc = (cnt == TC_VAL);

endmodule

// File: rtl/irrigacao_fsm.sv
// -----------------------------------------------------------------------------
// irrigacao_fsm
// Mode controller for the irrigation system. Sequences FILL -> DRIP/SPRAY ->
// (CLEAN every CLEAN_EVERY completed cycles) from user commands, tank/soil
// sensors and the phase timer, and drives the valves.
// Ports:
//   clk, rst_n     : clock (rising edge) and synchronous active-low reset
//   start, stop    : request / abort an irrigation cycle
//   sel_spray      : 0 = drip, 1 = sprinkle; latched when leaving IDLE
//   soil_dry       : 1 = irrigation needed
//   tank_full      : upper tank level sensor
//   tank_low       : lower tank level sensor
//   timer_done     : 1-cycle pulse, current phase time expired
//   fault_ack      : clears the watchdog fault
//   ff2, ff1       : phase code to the timer (00 fill, 01 drip, 10 spray,
//                    11 clean; 00 with active=0 in IDLE/FAULT)
//   mode_load      : 1-cycle pulse when a new active phase is first shown
//   active         : 1 in FILL/DRIP/SPRAY/CLEAN
//   valve_in/_drip/_spray/_drain : valve drives, at most one set at a time
//   fault          : fill watchdog expired
//   cycle_cnt      : irrigation cycles completed since the last clean
// All outputs are registered and change on the same edge as the state.
// -----------------------------------------------------------------------------
module irrigacao_fsm
   import irrig_pkg::*;
#(
   parameter int FILL_TIMEOUT = 1000,
   parameter int CLEAN_EVERY  = 4,
   parameter int CNT_W        = 10
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       stop,
   input  logic       sel_spray,
   input  logic       soil_dry,
   input  logic       tank_full,
   input  logic       tank_low,
   input  logic       timer_done,
   input  logic       fault_ack,
   output logic       ff1,
   output logic       ff2,
   output logic       mode_load,
   output logic       active,
   output logic       valve_in,
   output logic       valve_drip,
   output logic       valve_spray,
   output logic       valve_drain,
   output logic       fault,
   output logic [3:0] cycle_cnt
);

   localparam logic [3:0] CLEAN_CNT = 4'(CLEAN_EVERY);

   state_t     state_q, state_d;
   logic       sel_q, sel_d;
   logic [3:0] cnt_q, cnt_d;
   logic [3:0] cnt_inc;
   outs_t      outs_q, outs_d;
   logic       wd_tc;
   logic       wd_clr;
   logic       wd_en;

   // ---------------------------------------------------------------------
   // Fill watchdog: counts while in FILL; cleared whenever the next state
   // is anything other than FILL, so every FILL entry starts from zero.
   // ---------------------------------------------------------------------
   assign wd_en  = (state_q == S_FILL);
   assign wd_clr = (state_d != S_FILL);

   fill_watchdog #(
      .FILL_TIMEOUT (FILL_TIMEOUT),
      .CNT_W        (CNT_W)
   ) u_watchdog (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (wd_clr),
      .en    (wd_en),
      .tc    (wd_tc)
   );

   assign cnt_inc = cnt_q + 4'd1;

   // ---------------------------------------------------------------------
   // Next-state logic. Branch order encodes the in-cycle priority:
   // stop > fault timeout > tank_low > cycle complete > tank_full.
   // ---------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can
      // leave it unassigned and infer a latch.
      state_d = state_q;
      sel_d   = sel_q;
      cnt_d   = cnt_q;

      unique case (state_q)
         S_IDLE: begin
            if (start && soil_dry && !stop) begin
               sel_d = sel_spray;
               if (!tank_full)
                  state_d = S_FILL;
               else
                  state_d = sel_spray ? S_SPRAY : S_DRIP;
            end
         end

         S_FILL: begin
            // timer_done is deliberately ignored while filling.
            if (stop)
               state_d = S_IDLE;
            else if (wd_tc && !tank_full)
               state_d = S_FAULT;
            else if (tank_full)
               state_d = sel_q ? S_SPRAY : S_DRIP;
         end

         S_DRIP, S_SPRAY: begin
            if (stop) begin
               state_d = S_IDLE;
            end else if (tank_low) begin
               // Refill; sel_q is kept so the same mode resumes afterwards,
               // and the interrupted cycle is not counted.
               state_d = S_FILL;
            end else if (timer_done || !soil_dry) begin
               if (cnt_inc == CLEAN_CNT) begin
                  state_d = S_CLEAN;
                  cnt_d   = '0;
               end else begin
                  state_d = S_IDLE;
                  cnt_d   = cnt_inc;
               end
            end
         end

         S_CLEAN: begin
            if (stop || timer_done)
               state_d = S_IDLE;
         end

         S_FAULT: begin
            // stop and start have no effect until the fault is acknowledged.
            if (fault_ack)
               state_d = S_IDLE;
         end

         default: state_d = S_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------
   // Output decode from the next state, so the registered outputs line up
   // with the state register on the same edge.
   // ---------------------------------------------------------------------
   always_comb begin
      outs_d           = '0;
      outs_d.mode      = mode_of(state_d);
      outs_d.active    = is_phase(state_d);
      outs_d.valves    = valves_of(state_d);
      outs_d.fault     = (state_d == S_FAULT);
      // Pulse only on a change into an active phase (FILL<->DRIP included).
      outs_d.mode_load = is_phase(state_d) && (state_d != state_q);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         sel_q   <= 1'b0;
         cnt_q   <= '0;
         outs_q  <= '0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         cnt_q   <= cnt_d;
         outs_q  <= outs_d;
      end
   end

   assign ff1         = outs_q.mode[0];
   assign ff2         = outs_q.mode[1];
   assign mode_load   = outs_q.mode_load;
   assign active      = outs_q.active;
   assign valve_in    = outs_q.valves[VLV_IN];
   assign valve_drip  = outs_q.valves[VLV_DRIP];
   assign valve_spray = outs_q.valves[VLV_SPRAY];
   assign valve_drain = outs_q.valves[VLV_DRAIN];
   assign fault       = outs_q.fault;
   assign cycle_cnt   = cnt_q;

endmodule

// File: tb/tb_irrigacao_fsm.sv
// -----------------------------------------------------------------------------
// tb_irrigacao_fsm
// Self-checking bench for irrigacao_fsm. A phase-level behavioural model
// (phase number + lookup tables) predicts all outputs each clock; every
// negedge the DUT outputs are compared to it. Directed scenarios add literal
// expectations, then a long randomized run exercises the rest.
// -----------------------------------------------------------------------------
module tb_irrigacao_fsm;

   localparam int FILL_TIMEOUT = 8;
   localparam int CLEAN_EVERY  = 4;
   localparam int CNT_W        = 4;

   logic       clk = 1'b0;
   logic       rst_n, start, stop, sel_spray, soil_dry;
   logic       tank_full, tank_low, timer_done, fault_ack;
   logic       ff1, ff2, mode_load, active;
   logic       valve_in, valve_drip, valve_spray, valve_drain, fault;
   logic [3:0] cycle_cnt;

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_en  = 1'b0;

   irrigacao_fsm #(
      .FILL_TIMEOUT (FILL_TIMEOUT),
      .CLEAN_EVERY  (CLEAN_EVERY),
      .CNT_W        (CNT_W)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .stop        (stop),
      .sel_spray   (sel_spray),
      .soil_dry    (soil_dry),
      .tank_full   (tank_full),
      .tank_low    (tank_low),
      .timer_done  (timer_done),
      .fault_ack   (fault_ack),
      .ff1         (ff1),
      .ff2         (ff2),
      .mode_load   (mode_load),
      .active      (active),
      .valve_in    (valve_in),
      .valve_drip  (valve_drip),
      .valve_spray (valve_spray),
      .valve_drain (valve_drain),
      .fault       (fault),
      .cycle_cnt   (cycle_cnt)
   );

   always #5 clk = ~clk;

   // {ff2,ff1, mode_load, active, in,drip,spray,drain, fault, cycle_cnt}
   logic [12:0] act_v;
   assign act_v = {ff2, ff1, mode_load, active, valve_in, valve_drip,
                   valve_spray, valve_drain, fault, cycle_cnt};

   // ---------------------------------------------------------------------
   // Behavioural model: phase number plus per-phase output tables.
   // ---------------------------------------------------------------------
   localparam int P_IDLE = 0, P_FILL = 1, P_DRIP = 2, P_SPRAY = 3,
                  P_CLEAN = 4, P_FAULT = 5;

   logic [1:0] mode_tab  [6] = '{2'b00, 2'b00, 2'b01, 2'b10, 2'b11, 2'b00};
   logic [3:0] valve_tab [6] = '{4'b0000, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0000};

   int          m_ph  = P_IDLE;
   int          m_age = 0;     // edges spent in FILL since entering it
   int          m_cnt = 0;
   bit          m_sel = 1'b0;
   int          nxt;
   bit          irrigating, load;
   logic [12:0] exp_v = '0;

   always @(posedge clk) begin
      nxt        = m_ph;
      irrigating = (m_ph == P_DRIP) || (m_ph == P_SPRAY);
      if (!rst_n) begin
         nxt   = P_IDLE;
         m_sel = 1'b0;
         m_cnt = 0;
      end else if (m_ph == P_IDLE) begin
         if (start && soil_dry && !stop) begin
            m_sel = sel_spray;
            nxt   = !tank_full ? P_FILL : (sel_spray ? P_SPRAY : P_DRIP);
         end
      end else if (m_ph == P_FAULT) begin
         if (fault_ack) nxt = P_IDLE;
      end else if (stop) begin
         nxt = P_IDLE;
      end else if (m_ph == P_FILL && !tank_full && m_age + 1 == FILL_TIMEOUT) begin
         nxt = P_FAULT;
      end else if (irrigating && tank_low) begin
         nxt = P_FILL;
      end else if (irrigating && (timer_done || !soil_dry)) begin
         m_cnt = m_cnt + 1;
         if (m_cnt == CLEAN_EVERY) begin
            m_cnt = 0;
            nxt   = P_CLEAN;
         end else begin
            nxt = P_IDLE;
         end
      end else if (m_ph == P_CLEAN && timer_done) begin
         nxt = P_IDLE;
      end else if (m_ph == P_FILL && tank_full) begin
         nxt = m_sel ? P_SPRAY : P_DRIP;
      end

      m_age = (rst_n && m_ph == P_FILL && nxt == P_FILL) ? m_age + 1 : 0;
      load  = rst_n && (nxt >= P_FILL) && (nxt <= P_CLEAN) && (nxt != m_ph);
      exp_v = {mode_tab[nxt], load, (nxt >= P_FILL && nxt <= P_CLEAN),
               valve_tab[nxt], (nxt == P_FAULT), 4'(m_cnt)};
      m_ph  = nxt;
   end

   task automatic check(input string name, input logic [31:0] actual,
                        input logic [31:0] expected);
      n_tests++;
      if (actual !== expected) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, actual, expected, $time);
      end
   endtask

   // One clock: wait for the negedge, then compare every output to the model.
   task automatic step();
      @(negedge clk);
      if (chk_en) check("cycle_outputs", act_v, exp_v);
   endtask

   task automatic idle_inputs();
      start = 0; stop = 0; sel_spray = 0; soil_dry = 0;
      tank_full = 0; tank_low = 0; timer_done = 0; fault_ack = 0;
   endtask

   int p_full, p_low, p_done, p_dry;

   initial begin
      idle_inputs();
      rst_n = 1'b0;
      step();
      chk_en = 1'b1;
      step();
      check("reset_all_zero", act_v, 13'd0);

      // ---- Reset, then fill to drip ----
      rst_n = 1; start = 1; soil_dry = 1; tank_full = 0; sel_spray = 0;
      step();
      start = 0;
      check("fill_mode",  {ff2, ff1}, 2'b00);
      check("fill_valve", {valve_in, valve_drip, valve_spray, valve_drain}, 4'b1000);
      check("fill_load",  {mode_load, active}, 2'b11);
      step();
      check("fill_load_one_cycle", mode_load, 1'b0);
      tank_full = 1;
      step();
      check("drip_mode",  {ff2, ff1}, 2'b01);
      check("drip_valve", {valve_in, valve_drip, valve_spray, valve_drain}, 4'b0100);
      check("drip_load",  mode_load, 1'b1);

      // ---- Refill resumes mode ----
      tank_full = 0; tank_low = 1;
      step();
      check("refill_fill", {ff2, ff1, mode_load, valve_in}, 4'b0011);
      tank_low = 0; tank_full = 1;
      step();
      check("refill_resume", {ff2, ff1, mode_load, valve_drip}, 4'b0111);
      check("refill_cnt", cycle_cnt, 4'd0);

      // ---- tank_low beats timer_done in DRIP ----
      tank_low = 1; timer_done = 1;
      step();
      tank_low = 0; timer_done = 0;
      check("low_and_done_fill", {ff2, ff1, active, valve_in}, 4'b0011);
      check("low_and_done_cnt", cycle_cnt, 4'd0);
      step();
      check("back_to_drip", {ff2, ff1}, 2'b01);
      timer_done = 1;
      step();
      timer_done = 0;
      check("drip_complete", {active, cycle_cnt}, 5'b0_0001);
      rst_n = 0;
      step();
      rst_n = 1;

      // ---- Direct spray, then clean at count 4 ----
      tank_full = 1; sel_spray = 1; soil_dry = 1;
      for (int k = 1; k <= CLEAN_EVERY; k++) begin
         start = 1;
         step();
         start = 0;
         check("spray_mode", {ff2, ff1, valve_spray}, 3'b101);
         step();
         timer_done = 1;
         step();
         timer_done = 0;
         if (k < CLEAN_EVERY) begin
            check("spray_cnt", {active, cycle_cnt}, {1'b0, 4'(k)});
         end else begin
            check("clean_entry", {ff2, ff1, mode_load, valve_drain}, 4'b1111);
            check("clean_cnt_zero", cycle_cnt, 4'd0);
         end
      end
      timer_done = 1;
      step();
      timer_done = 0;
      check("clean_done_idle", active, 1'b0);

      // ---- stop and timer_done together in SPRAY ----
      start = 1;
      step();
      start = 0;
      stop = 1; timer_done = 1;
      step();
      stop = 0; timer_done = 0;
      check("stop_beats_done", {active, cycle_cnt}, 5'b0_0000);

      // ---- Watchdog fault ----
      tank_full = 0; start = 1;
      step();
      for (int i = 1; i < FILL_TIMEOUT; i++) begin
         step();
         check("wd_no_fault_yet", fault, 1'b0);
      end
      step();
      check("wd_fault", {fault, valve_in, valve_drip, valve_spray, valve_drain}, 5'b10000);
      step();
      check("fault_ignores_start", {fault, active}, 2'b10);
      fault_ack = 1; start = 0;
      step();
      fault_ack = 0;
      check("fault_ack_idle", {fault, active}, 2'b00);

      // ---- Reset mid-CLEAN ----
      tank_full = 1; sel_spray = 0;
      for (int k = 0; k < CLEAN_EVERY; k++) begin
         start = 1;
         step();
         start = 0; timer_done = 1;
         step();
         timer_done = 0;
      end
      check("reach_clean", {ff2, ff1, valve_drain}, 3'b111);
      rst_n = 0;
      step();
      rst_n = 1;
      check("reset_mid_clean", act_v, 13'd0);

      // ---- Randomized run against the model ----
      for (int blk = 0; blk < 8; blk++) begin
         p_full = (blk % 2 == 0) ? 15 : 70;
         p_low  = (blk % 3 == 0) ? 15 : 4;
         p_done = 8 + 4 * (blk % 3);
         p_dry  = (blk == 5) ? 50 : 85;
         for (int c = 0; c < 400; c++) begin
            rst_n      = ($urandom_range(299) != 0);
            start      = ($urandom_range(99) < 30);
            stop       = ($urandom_range(99) < 3);
            sel_spray  = ($urandom_range(1) == 1);
            soil_dry   = ($urandom_range(99) < p_dry);
            tank_full  = ($urandom_range(99) < p_full);
            tank_low   = ($urandom_range(99) < p_low);
            timer_done = ($urandom_range(99) < p_done);
            fault_ack  = ($urandom_range(99) < 20);
            step();
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
